uart_tx_controller: RTL and testbench
=====================================

# uart_tx_controller

Frame sequencer for the UART transmit path. It consumes the `sample_ENABLE` oversampling tick from `baud_controller` and serialises one data byte per request onto `TxD`. Each frame is a start bit, `DATA_W` data bits LSB-first, an optional even-parity bit and one stop bit, with every bit lasting `OVERSAMPLE` ticks. It sits between the host-side write interface and the pin, beside `baud_controller`, which it does not modify.

## Interface
- `OVERSAMPLE`, 16: `sample_ENABLE` ticks per bit; must be a power of two, ≥2.
- `DATA_W`, 8: data bits per frame, 5..8.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low (`reset`=0 resets on the next `clk` edge).
- `sample_ENABLE`  in  1  one-cycle tick from `baud_controller`.
- `Tx_EN`  in  1  transmitter enable; low forces and holds IDLE.
- `Tx_WR`  in  1  write strobe; sampled every cycle.
- `Tx_DATA`  in  `DATA_W`  byte to send; sampled only when a write is accepted.
- `TxD`  out  1  serial line, registered; idle high.
- `Tx_BUSY`  out  1  high from acceptance through the last stop-bit tick.
- `Tx_DONE`  out  1  one-cycle pulse when a frame completes normally.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Registers:
  - `shreg[DATA_W-1:0]`: data shift register.
  - `tick_cnt`: `log2(OVERSAMPLE)` bits.
  - `bit_cnt`: `clog2(DATA_W)` bits.
  - `par`: 1 bit.
- IDLE: `TxD`=1, `Tx_BUSY`=0.
  - Accept when `Tx_EN`=1 and `Tx_WR`=1.
  - On accept: `shreg`←`Tx_DATA`, `par`←^`Tx_DATA`, `tick_cnt`←0, `bit_cnt`←0, go to START.
- Bit advance: in any non-IDLE state, a cycle with `sample_ENABLE`=1 increments `tick_cnt`, which wraps modulo `OVERSAMPLE`. The tick with `tick_cnt`=`OVERSAMPLE`-1 is the bit's last tick and triggers the state step:
  - START → DATA.
  - DATA: shift `shreg` right and increment `bit_cnt`. When `bit_cnt`=`DATA_W`-1, go to PARITY (with the macro) or STOP (without it).
  - PARITY → STOP.
  - STOP → IDLE, pulse `Tx_DONE`.
- `TxD` per state: START 0; DATA `shreg[0]`; PARITY `par` (even parity: total count of ones over data and parity is even); STOP 1.
- `Tx_WR` while `Tx_BUSY`=1 is ignored. There is no buffering and no error flag.
- `Tx_EN` falling mid-frame: abort. On the next edge go to IDLE, `TxD`=1, `Tx_BUSY`=0, and `Tx_DONE` is not pulsed. The runt frame is intentional.
- `Tx_WR` in the same cycle that STOP completes is ignored, because the block is not yet in IDLE. It is accepted from the following cycle.

## Timing
- Reset values: `TxD`=1, `Tx_BUSY`=0, `Tx_DONE`=0, state IDLE, all counters 0.
- Reset mid-frame: same as abort. The line returns high on the edge that samples `reset`=0.
- Accept at edge N (`Tx_WR` high before N):
  - `Tx_BUSY`=1 and `TxD`=0 from edge N.
  - Each bit then spans exactly `OVERSAMPLE` `sample_ENABLE` pulses counted from edge N.
  - The start-bit width in clocks therefore depends on tick phase, and so does the width of every later bit.
- Frame length in ticks: `OVERSAMPLE`·(`DATA_W`+2), or `OVERSAMPLE`·(`DATA_W`+3) with parity.
- At the edge processing the last STOP tick:
  - `Tx_BUSY`→0.
  - `Tx_DONE`=1 for exactly that one cycle.
  - `TxD` stays 1.
- `Tx_EN` is checked before the bit-advance logic in the same cycle. It has priority over `sample_ENABLE` and over completion; an abort in the completion cycle suppresses `Tx_DONE`.
- `sample_ENABLE` pulses while in IDLE are ignored; `tick_cnt` holds 0.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: PARITY state compiled in, even-parity bit inserted after the data bits.
  - Undefined: PARITY state and `par` register removed; DATA goes directly to STOP.

## Test plan
- Tick every 4 clk (`OVERSAMPLE`=16), parity on, write 8'hA5:
  - `TxD` = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop), each bit 64 clk.
  - `Tx_DONE` pulses once after 176 ticks.
- Same as above with `UART_TX_PARITY_EN` undefined, write 8'h01:
  - Sequence 0,1,0,0,0,0,0,0,0,1.
  - Frame is 160 ticks long.
- Second `Tx_WR` with 8'hFF at tick 40 of an 8'h00 frame:
  - Ignored; line carries only the 8'h00 frame.
  - `Tx_BUSY` stays high throughout.
- `Tx_EN` dropped during data bit 3:
  - `TxD`=1 and `Tx_BUSY`=0 on the next edge.
  - No `Tx_DONE` pulse.
  - A fresh write then produces a full, correct frame.
- `reset`=0 asserted mid-frame:
  - Outputs at reset values on the next edge.
  - Writes with `reset`=0 are ignored.
- Back-to-back: `Tx_WR` held high continuously with 8'h3C:
  - Frames separated by exactly one IDLE cycle.
  - One `Tx_DONE` per frame.

Source files
------------

// File: rtl/uart_tx_controller_if.sv
// Host-side write interface of the UART transmit frame sequencer.
// Build option: UART_TX_PARITY_EN (affects only uart_tx_controller).
// Signals:
//   Tx_EN    host -> tx   transmitter enable; low aborts and holds idle
//   Tx_WR    host -> tx   write strobe
//   Tx_DATA  host -> tx   byte to send, sampled on acceptance
//   Tx_BUSY  tx -> host   frame in progress
//   Tx_DONE  tx -> host   one-cycle pulse on normal frame completion
interface uart_tx_controller_if #(
   parameter int unsigned DATA_W = 8
);
   logic              Tx_EN;
   logic              Tx_WR;
   logic [DATA_W-1:0] Tx_DATA;
   logic              Tx_BUSY;
   logic              Tx_DONE;

   modport master (output Tx_EN, Tx_WR, Tx_DATA, input Tx_BUSY, Tx_DONE);
   modport slave  (input Tx_EN, Tx_WR, Tx_DATA, output Tx_BUSY, Tx_DONE);
endinterface

// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: start bit, DATA_W data bits LSB-first,
// optional even-parity bit (build with UART_TX_PARITY_EN), one stop bit.
// Each bit lasts OVERSAMPLE sample_ENABLE ticks.
// Ports:
//   clk            system clock
//   reset          synchronous, active-low
//   sample_ENABLE  oversampling tick from baud_controller
//   TxD            registered serial line, idle high
//   tx_if          host write interface (Tx_EN, Tx_WR, Tx_DATA, Tx_BUSY, Tx_DONE)
module uart_tx_controller #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_ENABLE,
   output logic                 TxD,
   uart_tx_controller_if.slave  tx_if
);

   localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                txd_q, txd_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                par_q, par_d;
`endif

   assign TxD           = txd_q;
   assign tx_if.Tx_BUSY = busy_q;
   assign tx_if.Tx_DONE = done_q;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   // Next state, bit sequencing and output decode
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d      = par_q;
`endif

      // Enable outranks both tick advance and completion
      if (!tx_if.Tx_EN) begin
         state_d    = S_IDLE;
         tick_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (state_q == S_IDLE) begin
         if (tx_if.Tx_WR) begin
            shreg_d    = tx_if.Tx_DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_START;
`ifdef UART_TX_PARITY_EN
            par_d      = ^tx_if.Tx_DATA;
`endif
         end
      end else if (sample_ENABLE) begin
         // Tick counter wraps naturally, so it is back at 0 after each bit
         tick_cnt_d = tick_cnt_q + TICK_W'(1);
         if (tick_cnt_q == TICK_LAST) begin
            case (state_q)
               S_START: state_d = S_DATA;
               S_DATA: begin
                  shreg_d   = shreg_q >> 1;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                     state_d   = S_PARITY;
`else
                     state_d   = S_STOP;
`endif
                  end
               end
`ifdef UART_TX_PARITY_EN
               S_PARITY: state_d = S_STOP;
`endif
               S_STOP: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end

      // Outputs are decoded from the next state so they register in step with it
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_d = par_d;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Self-checking bench for uart_tx_controller: directed scenarios plus a
// randomized phase, all checked every cycle against a frame-level model
// (bit list plus tick count since acceptance).
module tb_uart_tx_controller;

   localparam int unsigned OS = 16;
   localparam int unsigned DW = 8;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = DW + 3;
`else
   localparam int unsigned NBITS = DW + 2;
`endif
   localparam int unsigned FRAME_TICKS = OS * NBITS;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic se = 1'b0;
   logic txd;

   uart_tx_controller_if #(.DATA_W(DW)) tx_if ();

   uart_tx_controller #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .sample_ENABLE (se),
      .TxD           (txd),
      .tx_if         (tx_if)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // model state
   logic m_busy = 1'b0;
   logic m_txd  = 1'b1;
   logic m_done = 1'b0;
   int   m_ticks = 0;
   logic m_frame [0:15];

   // bench bookkeeping on observed DUT outputs
   int   tick_mode = 0;
   int   phase = 0;
   int   done_seen = 0;
   int   busy_ticks = 0;
   int   idle_run = 0;
   int   last_gap = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
   endtask

   task automatic model_step(input logic rst_v, input logic en_v, input logic wr_v,
                             input logic se_v, input logic [DW-1:0] d_v);
      if (!rst_v || !en_v) begin
         m_busy = 1'b0; m_txd = 1'b1; m_done = 1'b0; m_ticks = 0;
      end else if (!m_busy) begin
         m_done = 1'b0;
         m_txd  = 1'b1;
         if (wr_v) begin
            m_frame[0] = 1'b0;
            for (int i = 0; i < int'(DW); i++) m_frame[i+1] = d_v[i];
`ifdef UART_TX_PARITY_EN
            m_frame[DW+1] = ^d_v;
`endif
            m_frame[NBITS-1] = 1'b1;
            m_busy  = 1'b1;
            m_ticks = 0;
            m_txd   = m_frame[0];
         end
      end else begin
         m_done = 1'b0;
         if (se_v) begin
            m_ticks++;
            if (m_ticks == int'(FRAME_TICKS)) begin
               m_busy = 1'b0; m_done = 1'b1; m_txd = 1'b1; m_ticks = 0;
            end else begin
               m_txd = m_frame[m_ticks / int'(OS)];
            end
         end
      end
   endtask

   // One clock: drive inputs, step model at the edge, compare 1 time unit later
   task automatic cycle(input logic rst_v, input logic en_v, input logic wr_v,
                        input logic [DW-1:0] d_v);
      logic se_v;
      logic prev_busy;
      if (tick_mode != 0) se_v = ($urandom_range(0, 3) == 0);
      else                se_v = (phase == 0);
      phase = (phase + 1) % 4;
      reset = rst_v; se = se_v;
      tx_if.Tx_EN = en_v; tx_if.Tx_WR = wr_v; tx_if.Tx_DATA = d_v;
      prev_busy = tx_if.Tx_BUSY;
      @(posedge clk);
      model_step(rst_v, en_v, wr_v, se_v, d_v);
      #1;
      chk("TxD",     32'(txd),           32'(m_txd));
      chk("Tx_BUSY", 32'(tx_if.Tx_BUSY), 32'(m_busy));
      chk("Tx_DONE", 32'(tx_if.Tx_DONE), 32'(m_done));
      if (tx_if.Tx_DONE === 1'b1) done_seen++;
      if (prev_busy === 1'b1 && se_v && rst_v && en_v) busy_ticks++;
      if (tx_if.Tx_BUSY !== 1'b1) idle_run++;
      else begin
         if (idle_run > 0) last_gap = idle_run;
         idle_run = 0;
      end
   endtask

   task automatic clear_stats();
      done_seen = 0; busy_ticks = 0; idle_run = 0; last_gap = 0; phase = 0;
   endtask

   task automatic run_to_idle(input int budget);
      int n;
      n = 0;
      while (m_busy && n < budget) begin
         cycle(1'b1, 1'b1, 1'b0, DW'(0));
         n++;
      end
      if (m_busy) chk("idle_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      logic [11:0] seq_v;
      logic [DW-1:0] d;
      int sidx;
      int busy_low;
      int n;

      tx_if.Tx_EN = 1'b0; tx_if.Tx_WR = 1'b0; tx_if.Tx_DATA = '0;

      // Reset, with writes attempted while reset is low
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, DW'(8'h5A));
      chk("rst_txd",  32'(txd),           32'(1));
      chk("rst_busy", 32'(tx_if.Tx_BUSY), 32'(0));
      chk("rst_done", 32'(tx_if.Tx_DONE), 32'(0));
      cycle(1'b1, 1'b1, 1'b0, DW'(0));
      cycle(1'b1, 1'b1, 1'b0, DW'(0));

      // Directed frame, tick every 4 clk, line sampled mid-bit against a fixed sequence
`ifdef UART_TX_PARITY_EN
      d = DW'(8'hA5); seq_v = 12'b0_10101001010;
`else
      d = DW'(8'h01); seq_v = 12'b00_1000000010;
`endif
      clear_stats();
      sidx = 0;
      cycle(1'b1, 1'b1, 1'b1, d);
      n = 0;
      while (m_busy && n < 2000) begin
         if (sidx < int'(NBITS) && m_ticks == sidx * int'(OS) + int'(OS) / 2) begin
            chk("seq_bit", 32'(txd), 32'(seq_v[sidx]));
            sidx++;
         end
         cycle(1'b1, 1'b1, 1'b0, DW'(0));
         n++;
      end
      if (m_busy) chk("frame1_timeout", 32'(0), 32'(1));
      chk("seq_count",    32'(sidx),       32'(NBITS));
      chk("frame1_done",  32'(done_seen),  32'(1));
      chk("frame1_ticks", 32'(busy_ticks), 32'(FRAME_TICKS));
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, DW'(0));

      // Second write at tick 40 of a 8'h00 frame is ignored
      clear_stats();
      busy_low = 0;
      cycle(1'b1, 1'b1, 1'b1, DW'(8'h00));
      n = 0;
      while (m_ticks < 40 && n < 1000) begin
         cycle(1'b1, 1'b1, 1'b0, DW'(0)); n++;
         if (m_busy && tx_if.Tx_BUSY !== 1'b1) busy_low++;
      end
      cycle(1'b1, 1'b1, 1'b1, DW'(8'hFF));
      n = 0;
      while (m_busy && n < 2000) begin
         if (tx_if.Tx_BUSY !== 1'b1) busy_low++;
         cycle(1'b1, 1'b1, 1'b0, DW'(0)); n++;
      end
      if (m_busy) chk("frame2_timeout", 32'(0), 32'(1));
      chk("wr_ignored_busy", 32'(busy_low),   32'(0));
      chk("frame2_done",     32'(done_seen),  32'(1));
      chk("frame2_ticks",    32'(busy_ticks), 32'(FRAME_TICKS));
      cycle(1'b1, 1'b1, 1'b0, DW'(0));

      // Enable dropped during data bit 3, then a fresh full frame
      clear_stats();
      cycle(1'b1, 1'b1, 1'b1, DW'($urandom));
      n = 0;
      while (m_ticks < 4 * int'(OS) + 5 && n < 1000) begin
         cycle(1'b1, 1'b1, 1'b0, DW'(0)); n++;
      end
      cycle(1'b1, 1'b0, 1'b0, DW'(0));
      chk("abort_txd",  32'(txd),           32'(1));
      chk("abort_busy", 32'(tx_if.Tx_BUSY), 32'(0));
      cycle(1'b1, 1'b0, 1'b1, DW'(0));
      cycle(1'b1, 1'b1, 1'b0, DW'(0));
      chk("abort_no_done", 32'(done_seen), 32'(0));
      clear_stats();
      cycle(1'b1, 1'b1, 1'b1, DW'($urandom));
      run_to_idle(2000);
      chk("after_abort_done",  32'(done_seen),  32'(1));
      chk("after_abort_ticks", 32'(busy_ticks), 32'(FRAME_TICKS));

      // Reset mid-frame with writes during reset
      clear_stats();
      cycle(1'b1, 1'b1, 1'b1, DW'($urandom));
      for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1'b0, DW'(0));
      cycle(1'b0, 1'b1, 1'b1, DW'(8'hFF));
      chk("midrst_txd",  32'(txd),           32'(1));
      chk("midrst_busy", 32'(tx_if.Tx_BUSY), 32'(0));
      cycle(1'b0, 1'b1, 1'b1, DW'(8'hFF));
      chk("midrst_wr_ignored", 32'(tx_if.Tx_BUSY), 32'(0));
      cycle(1'b1, 1'b1, 1'b0, DW'(0));
      chk("midrst_no_done", 32'(done_seen), 32'(0));

      // Back-to-back with write held high
      clear_stats();
      n = 0;
      while (done_seen < 3 && n < 3 * int'(FRAME_TICKS) * 4 + 100) begin
         cycle(1'b1, 1'b1, 1'b1, DW'(8'h3C)); n++;
      end
      chk("b2b_done", 32'(done_seen),  32'(3));
      chk("b2b_gap",  32'(last_gap),   32'(1));
      chk("b2b_ticks", 32'(busy_ticks), 32'(3 * FRAME_TICKS));
      cycle(1'b1, 1'b1, 1'b0, DW'(0));

      // Randomized traffic with random tick spacing, enable drops and resets
      tick_mode = 1;
      for (int i = 0; i < 8000; i++) begin
         cycle(($urandom_range(0, 999) != 0),
               ($urandom_range(0, 299) != 0),
               ($urandom_range(0, 9) == 0),
               DW'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
